// File: rtl/decode_issue_scoreboard.sv
// Single-entry decode/issue buffer with a per-register pending-write scoreboard.
// Optional DECODE_ISSUE_SCOREBOARD_CMP_BYPASS_EN lets a same-cycle completion clear a hazard.
module decode_issue_scoreboard #(
  parameter int unsigned UOP_W = 6,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_val,
  output logic             dec_rdy,
  input  logic [UOP_W-1:0] dec_uop,
  input  logic [4:0]       dec_raddr0,
  input  logic [4:0]       dec_raddr1,
  input  logic [4:0]       dec_waddr,
  input  logic             dec_wen,
  output logic             iss_val,
  input  logic             iss_rdy,
  output logic [UOP_W-1:0] iss_uop,
  output logic [4:0]       iss_raddr0,
  output logic [4:0]       iss_raddr1,
  output logic [4:0]       iss_waddr,
  output logic             iss_wen,
  input  logic             cmp_val,
  input  logic [4:0]       cmp_waddr,
  input  logic             squash,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [CNT_W-1:0] cnt_r0, cnt_r1, cnt_w;
  logic             byp0, byp1, bypw;
  logic             hazard0, hazard1, waw_full;
  logic             fire, accept, inc, dec, err_set;

  assign cnt_r0 = cnt_q[iss_raddr0];
  assign cnt_r1 = cnt_q[iss_raddr1];
  assign cnt_w  = cnt_q[iss_waddr];

`ifdef DECODE_ISSUE_SCOREBOARD_CMP_BYPASS_EN
  // The last outstanding write completing this cycle no longer blocks the reader.
  assign byp0 = cmp_val && (cmp_waddr == iss_raddr0) && (cnt_r0 == CNT_W'(1));
  assign byp1 = cmp_val && (cmp_waddr == iss_raddr1) && (cnt_r1 == CNT_W'(1));
  assign bypw = cmp_val && (cmp_waddr == iss_waddr);
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
  assign bypw = 1'b0;
`endif

  assign hazard0  = (iss_raddr0 != 5'd0) && (cnt_r0 != '0) && !byp0;
  assign hazard1  = (iss_raddr1 != 5'd0) && (cnt_r1 != '0) && !byp1;
  assign waw_full = iss_wen && (iss_waddr != 5'd0) && (cnt_w == CntMax) && !bypw;

  assign iss_val = (state_q == StFull) && !hazard0 && !hazard1 && !waw_full && !squash;
  assign fire    = iss_val && iss_rdy;
  assign dec_rdy = ((state_q == StEmpty) || fire) && !squash;
  assign accept  = dec_val && dec_rdy;
  assign inc     = fire && iss_wen && (iss_waddr != 5'd0);
  assign dec     = cmp_val && (cmp_waddr != 5'd0);

  always_comb begin
    err_set = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int unsigned r = 1; r < NREGS; r++) begin
      // Issue and completion on the same register cancel out.
      if (inc && (iss_waddr == 5'(r)) && !(dec && (cmp_waddr == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec && (cmp_waddr == 5'(r)) && !(inc && (iss_waddr == 5'(r)))) begin
        if (cnt_q[r] == '0) begin
          err_set = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      iss_uop    <= '0;
      iss_raddr0 <= '0;
      iss_raddr1 <= '0;
      iss_waddr  <= '0;
      iss_wen    <= 1'b0;
      sb_err     <= 1'b0;
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      sb_err <= sb_err | err_set;
      if (squash) begin
        state_q <= StEmpty;
      end else if (accept) begin
        state_q    <= StFull;
        iss_uop    <= dec_uop;
        iss_raddr0 <= dec_raddr0;
        iss_raddr1 <= dec_raddr1;
        iss_waddr  <= dec_waddr;
        iss_wen    <= dec_wen;
      end else if (fire) begin
        state_q <= StEmpty;
      end
    end
  end

endmodule

// File: doc/decode_issue_scoreboard.md
Name: decode_issue_scoreboard

Overview:
- Sits directly downstream of the combinational instruction decoder in the decode/issue stage.
- Registers one decoded micro-op into a single-entry issue buffer.
- Tracks pending register writes in a per-register scoreboard and releases the micro-op to the execute units only when its source operands are free and a pending-count slot is available for its destination.
- Writeback completions clear scoreboard entries.

Parameters:
- UOP_W, 6, width of the decoded micro-op code.
- CNT_W, 2, width of each per-register pending-write counter; at most 2^CNT_W-1 writes per register may be in flight.
- NREGS, 32, number of architectural registers; x0 is never tracked.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dec_val  in  1  decoded micro-op valid (decoder val AND fetch valid)
- dec_rdy  out  1  issue buffer can accept this cycle
- dec_uop  in  UOP_W  micro-op code
- dec_raddr0  in  5  source register 0
- dec_raddr1  in  5  source register 1
- dec_waddr  in  5  destination register
- dec_wen  in  1  destination write enable
- iss_val  out  1  micro-op issuing to execute
- iss_rdy  in  1  execute can accept
- iss_uop / iss_raddr0 / iss_raddr1 / iss_waddr / iss_wen  out  UOP_W/5/5/5/1  buffered fields
- cmp_val  in  1  writeback completion valid
- cmp_waddr  in  5  completed destination register
- squash  in  1  discard buffered micro-op
- sb_err  out  1  sticky: completion arrived for a register with count 0

Behaviour:
- Reset (asynchronous, rst_n low): buffer goes to EMPTY; all counters are 0; iss_val=0; dec_rdy=1 once reset deasserts; sb_err=0; iss_* fields are 0.
- States: EMPTY and FULL.
  - EMPTY: dec_val&&dec_rdy captures all dec_* fields and moves to FULL. The minimum latency is 1 cycle: capture at edge N, so iss_val can be 1 in cycle N+1.
  - FULL with the fire condition true: if a new micro-op is accepted in the same cycle, stay FULL with the new micro-op; otherwise go to EMPTY.
- Hazard logic:
  - hazard0 = iss_raddr0!=0 && cnt[iss_raddr0]!=0.
  - hazard1 is defined the same way for raddr1.
  - waw_full = iss_wen && iss_waddr!=0 && cnt[iss_waddr]==2^CNT_W-1.
- Handshake:
  - iss_val = FULL && !hazard0 && !hazard1 && !waw_full && !squash.
  - fire = iss_val && iss_rdy.
  - dec_rdy = EMPTY || fire. This is a combinational pass-through, not registered.
  - iss_val never depends on iss_rdy.
  - A held micro-op keeps its fields stable until fire or squash.
- Counters:
  - On fire with iss_wen && iss_waddr!=0: cnt[iss_waddr] += 1.
  - On cmp_val with cmp_waddr!=0: cnt[cmp_waddr] -= 1.
  - Same register on both in one cycle: net unchanged.
  - Different registers: both updates apply.
  - cmp_waddr==0 is ignored.
- Underflow: a completion for a register whose count is 0 leaves the count at 0 and sets sb_err, which stays set until reset.
- Squash:
  - Buffer goes to EMPTY next edge; the squashed micro-op does not fire and does not increment its counter.
  - dec_rdy is 0 while squash is asserted, so nothing is captured that cycle.
  - Scoreboard counters are untouched, because in-flight writes still complete.
- Reset mid-operation clears counters even when writes are in flight. The system resets execute and writeback together.
- cnt[0] is hardwired to 0.

Optional Feature:
- Macro: DECODE_ISSUE_SCOREBOARD_CMP_BYPASS_EN.
- When defined:
  - A source hazard is suppressed if, in the same cycle, cmp_val && cmp_waddr==src && cnt[src]==1.
  - The micro-op may fire in the completion cycle; writeback data forwarding is the execute stage's job.
  - waw_full is likewise relieved when a completion to iss_waddr arrives in the same cycle.
- When undefined: hazards use only registered counts, so issue happens at the earliest one cycle after the clearing completion.

Test Plan:
- Back-to-back independent ops (add x1,x2,x3 then add x4,x5,x6, iss_rdy=1): both fire in consecutive cycles; dec_rdy stays 1; cnt[1]=1 and cnt[4]=1.
- RAW stall: add x1 fires, then add x7,x1,x2 is held with iss_val=0. With cmp_val on x1 in cycle K, iss_val=1 in K+1 without the bypass macro, or in K with it.
- WAW saturation (CNT_W=2): three writes to x5 fire with no completions, the fourth is held. One cmp on x5 lets it fire the next cycle; cnt[5] returns to 3.
- Backpressure: iss_rdy=0 for 4 cycles with FULL and no hazard. iss_val=1 and fields stay stable, dec_rdy=0, no counter change. iss_rdy=1 gives exactly one fire.
- Squash plus simultaneous fire/complete on one register:
  - squash while held: the buffer empties and cnt is unchanged.
  - fire of a write to x3 together with cmp x3 at cnt[3]=1: cnt[3] stays 1.
- x0 and underflow: a write to x0 fires with cnt[0]=0 and never stalls readers of x0. cmp on x9 with cnt[9]=0 sets sb_err=1 until rst_n is pulsed low.
